alu_op_decoder: RTL and testbench

- Registered decode stage that produces the `uop`/`f7`/operand-select bundle consumed by the RV32 ALU.
- Accepts one 32-bit instruction per cycle over a valid/ready interface.
- Decodes operation, immediate and register indices.
- Presents them over a valid/ready output backed by a 2-entry skid buffer, so a stall in the execute stage never drops or duplicates an instruction.

---
 rtl/alu_pkg.sv | 67 ++++++
 rtl/skid_buf.sv | 64 ++++++
 rtl/alu_op_decoder.sv | 175 +++++++++++++++++
 tb/tb_alu_op_decoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the RV32 ALU decode stage: ALU micro-op encoding,
// RV32 opcodes, operand-1 selects, funct7 values and the decoded bundle.
package alu_pkg;

   // ALU micro-op encoding, shared with the ALU
   localparam logic [2:0] UOP_ADD_SUB = 3'b000;
   localparam logic [2:0] UOP_SL      = 3'b001;
   localparam logic [2:0] UOP_SLT     = 3'b010;
   localparam logic [2:0] UOP_SLTU    = 3'b011;
   localparam logic [2:0] UOP_AND     = 3'b100;
   localparam logic [2:0] UOP_SR      = 3'b101;
   localparam logic [2:0] UOP_OR      = 3'b110;
   localparam logic [2:0] UOP_XOR     = 3'b111;

   // RV32 major opcodes (full 7 bits, so instr[1:0]!=11 never matches)
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Operand-1 source select
   localparam logic [1:0] OP1_RS1  = 2'd0;
   localparam logic [1:0] OP1_PC   = 2'd1;
   localparam logic [1:0] OP1_ZERO = 2'd2;

   // funct7 values
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef struct packed {
      logic [2:0]  uop;
      logic        f7;
      logic [1:0]  op1_sel;
      logic        op2_imm;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        is_branch;
      logic        is_load;
      logic        is_store;
      logic        is_jump;
      logic        is_muldiv;
      logic        illegal;
   } dec_bundle_t;

   localparam int BUNDLE_W = $bits(dec_bundle_t);

   // RISC-V funct3 to ALU uop: only the logic ops differ
   function automatic logic [2:0] remap_f3(input logic [2:0] f3);
      logic [2:0] u;
      case (f3)
         3'b100:  u = UOP_XOR;
         3'b110:  u = UOP_OR;
         3'b111:  u = UOP_AND;
         default: u = f3;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready buffer (main + skid registers). in_ready is a
// function of registered state only, so it never combinationally follows
// out_ready.
module skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   // Handshake: a transfer happens on a rising edge where valid & ready are
   // both high; valid never depends on ready, and data is held stable while
   // valid & ~ready.

   logic             main_valid;
   logic             skid_valid;
   logic             live_q;
   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] skid_data;
   logic             accept;
   logic             main_free;

   // live_q keeps in_ready low for the reset cycle itself
   assign in_ready  = live_q & ~skid_valid;
   assign accept    = in_valid & in_ready;
   assign main_free = ~main_valid | out_ready;
   assign out_valid = main_valid;
   assign out_data  = main_data;

   // Main/skid update: refill main from skid first, else from the input
   always_ff @(posedge clk) begin
      if (rst) begin
         live_q     <= 1'b0;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
      end else begin
         live_q <= 1'b1;
         if (main_free) begin
            if (skid_valid) begin
               main_data  <= skid_data;
               main_valid <= 1'b1;
               skid_valid <= 1'b0;
            end else if (accept) begin
               main_data  <= in_data;
               main_valid <= 1'b1;
            end else begin
               main_valid <= 1'b0;
            end
         end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_op_decoder.sv
// RV32 decode stage feeding the ALU: combinational decode of the incoming
// instruction into a uop/operand-select bundle, registered through a 2-entry
// skid buffer. Optional M-extension decode enabled by ALU_DEC_RV32M_EN.
module alu_op_decoder
   import alu_pkg::*;
#(
   parameter int PC_W  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_uop,
   output logic             out_f7,
   output logic [1:0]       out_op1_sel,
   output logic             out_op2_imm,
   output logic [31:0]      out_imm,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic             out_is_branch,
   output logic             out_is_load,
   output logic             out_is_store,
   output logic             out_is_jump,
   output logic             out_is_muldiv,
   output logic             out_illegal,
   output logic [PC_W-1:0]  out_pc,
   output logic [TAG_W-1:0] out_tag
);

   localparam int W = BUNDLE_W + PC_W + TAG_W;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        illegal;
   dec_bundle_t dec;
   dec_bundle_t out_b;
   logic [W-1:0] buf_out;

   assign opcode = in_instr[6:0];
   assign f3     = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u  = {in_instr[31:12], 12'b0};
   assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

   // Decode the offered instruction; illegal ones collapse to a zero bundle
   always_comb begin
      dec     = '0;
      illegal = 1'b0;
      dec.rs1 = in_instr[19:15];
      dec.rs2 = in_instr[24:20];
      dec.rd  = in_instr[11:7];
      case (opcode)
         OPC_OP: begin
            dec.uop = remap_f3(f3);
            case (funct7)
               F7_BASE: dec.f7 = 1'b0;
               F7_ALT: begin
                  if (f3 == 3'b000 || f3 == 3'b101) dec.f7 = 1'b1;
                  else                              illegal = 1'b1;
               end
`ifdef ALU_DEC_RV32M_EN
               F7_MULDIV: begin
                  dec.uop       = f3;
                  dec.is_muldiv = 1'b1;
               end
`endif
               default: illegal = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            dec.uop     = remap_f3(f3);
            dec.op2_imm = 1'b1;
            dec.imm     = imm_i;
            if (f3 == 3'b001 || f3 == 3'b101) begin
               if (funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
               else if (f3 == 3'b101 && in_instr[30])     dec.f7 = 1'b1;
            end
         end
         OPC_LUI: begin
            dec.op1_sel = OP1_ZERO;
            dec.op2_imm = 1'b1;
            dec.imm     = imm_u;
         end
         OPC_AUIPC: begin
            dec.op1_sel = OP1_PC;
            dec.op2_imm = 1'b1;
            dec.imm     = imm_u;
         end
         OPC_JAL: begin
            dec.op1_sel = OP1_PC;
            dec.op2_imm = 1'b1;
            dec.imm     = imm_j;
            dec.is_jump = 1'b1;
         end
         OPC_JALR: begin
            dec.op2_imm = 1'b1;
            dec.imm     = imm_i;
            dec.is_jump = 1'b1;
            if (f3 != 3'b000) illegal = 1'b1;
         end
         OPC_LOAD: begin
            dec.op2_imm = 1'b1;
            dec.imm     = imm_i;
            dec.is_load = 1'b1;
         end
         OPC_STORE: begin
            dec.op2_imm  = 1'b1;
            dec.imm      = imm_s;
            dec.is_store = 1'b1;
         end
         OPC_BRANCH: begin
            dec.imm       = imm_b;
            dec.is_branch = 1'b1;
            case (f3)
               3'b000, 3'b001: begin
                  dec.uop = UOP_ADD_SUB;
                  dec.f7  = 1'b1;
               end
               3'b100, 3'b101: dec.uop = UOP_SLT;
               3'b110, 3'b111: dec.uop = UOP_SLTU;
               default:        illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   skid_buf #(.WIDTH(W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({dec, in_pc, in_tag}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out)
   );

   assign out_b         = buf_out[W-1 -: BUNDLE_W];
   assign out_pc        = buf_out[PC_W+TAG_W-1 -: PC_W];
   assign out_tag       = buf_out[TAG_W-1:0];
   assign out_uop       = out_b.uop;
   assign out_f7        = out_b.f7;
   assign out_op1_sel   = out_b.op1_sel;
   assign out_op2_imm   = out_b.op2_imm;
   assign out_imm       = out_b.imm;
   assign out_rs1       = out_b.rs1;
   assign out_rs2       = out_b.rs2;
   assign out_rd        = out_b.rd;
   assign out_is_branch = out_b.is_branch;
   assign out_is_load   = out_b.is_load;
   assign out_is_store  = out_b.is_store;
   assign out_is_jump   = out_b.is_jump;
   assign out_is_muldiv = out_b.is_muldiv;
   assign out_illegal   = out_b.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: directed test-plan instructions, backpressure,
// reset flush and random stimulus against a behavioural decode model.
module tb_alu_op_decoder;

  localparam int PC_W  = 32;
  localparam int TAG_W = 4;
  localparam int EW    = 60 + PC_W + TAG_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_uop;
  logic             out_f7;
  logic [1:0]       out_op1_sel;
  logic             out_op2_imm;
  logic [31:0]      out_imm;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic             out_is_branch, out_is_load, out_is_store, out_is_jump;
  logic             out_is_muldiv, out_illegal;
  logic [PC_W-1:0]  out_pc;
  logic [TAG_W-1:0] out_tag;

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;  // 0: hold off, 1: always ready, 2: random
  logic [EW-1:0] exp_q[$];

  alu_op_decoder #(.PC_W(PC_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_uop(out_uop), .out_f7(out_f7), .out_op1_sel(out_op1_sel),
    .out_op2_imm(out_op2_imm), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_is_branch(out_is_branch), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_is_jump(out_is_jump),
    .out_is_muldiv(out_is_muldiv), .out_illegal(out_illegal),
    .out_pc(out_pc), .out_tag(out_tag)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input bit ok, input string name,
                     input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [59:0] pack(
    input logic [2:0] uop, input logic f7, input logic [1:0] op1,
    input logic op2i, input logic [31:0] imm, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [4:0] rd, input logic br,
    input logic ld, input logic st, input logic jp, input logic md,
    input logic ill);
    return {uop, f7, op1, op2i, imm, rs1, rs2, rd, br, ld, st, jp, md, ill};
  endfunction

  // Reference decode written from the instruction-set rules
  function automatic logic [59:0] model(input logic [31:0] w);
    int op = int'(w[6:0]);
    int f3 = int'(w[14:12]);
    int f7 = int'(w[31:25]);
    int si = int'($signed(w));
    int alu_code[8] = '{0, 1, 2, 3, 7, 5, 6, 4};
    logic [2:0]  uop = 3'd0;
    logic        f7b = 1'b0, op2i = 1'b0;
    logic [1:0]  op1 = 2'd0;
    logic [31:0] imm = 32'd0;
    logic br = 1'b0, ld = 1'b0, st = 1'b0, jp = 1'b0, md = 1'b0, ill = 1'b0;
    int imm_i = si >>> 20;
    int imm_s = (si >>> 25) * 32 + int'(w[11:7]);
    int imm_b = (si >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                + int'(w[11:8]) * 2;
    int imm_j = (si >>> 31) * 1048576 + int'(w[19:12]) * 4096
                + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    case (op)
      'h33: begin
        if (f7 == 0) uop = 3'(alu_code[f3]);
        else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) begin
          uop = 3'(alu_code[f3]); f7b = 1'b1;
        end
`ifdef ALU_DEC_RV32M_EN
        else if (f7 == 1) begin uop = 3'(f3); md = 1'b1; end
`endif
        else ill = 1'b1;
      end
      'h13: begin
        op2i = 1'b1; imm = 32'(imm_i); uop = 3'(alu_code[f3]);
        if (f3 == 1 || f3 == 5) begin
          if (f7 != 0 && f7 != 'h20) ill = 1'b1;
          else if (f3 == 5 && w[30]) f7b = 1'b1;
        end
      end
      'h37: begin op1 = 2'd2; op2i = 1'b1; imm = w & 32'hFFFF_F000; end
      'h17: begin op1 = 2'd1; op2i = 1'b1; imm = w & 32'hFFFF_F000; end
      'h6F: begin op1 = 2'd1; op2i = 1'b1; imm = 32'(imm_j); jp = 1'b1; end
      'h67: begin
        op2i = 1'b1; imm = 32'(imm_i); jp = 1'b1;
        if (f3 != 0) ill = 1'b1;
      end
      'h03: begin op2i = 1'b1; imm = 32'(imm_i); ld = 1'b1; end
      'h23: begin op2i = 1'b1; imm = 32'(imm_s); st = 1'b1; end
      'h63: begin
        imm = 32'(imm_b); br = 1'b1;
        if (f3 == 2 || f3 == 3) ill = 1'b1;
        else if (f3 < 2) f7b = 1'b1;
        else if (f3 < 6) uop = 3'd2;
        else uop = 3'd3;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin uop = 3'd0; f7b = 1'b0; md = 1'b0; end
    return pack(uop, f7b, op1, op2i, imm, w[19:15], w[24:20], w[11:7],
                br, ld, st, jp, md, ill);
  endfunction

  function automatic logic [EW-1:0] act_vec();
    return {pack(out_uop, out_f7, out_op1_sel, out_op2_imm, out_imm, out_rs1,
                 out_rs2, out_rd, out_is_branch, out_is_load, out_is_store,
                 out_is_jump, out_is_muldiv, out_illegal), out_pc, out_tag};
  endfunction

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- input driver ----------------
  task automatic send(input logic [31:0] w, input logic [PC_W-1:0] pc,
                      input logic [TAG_W-1:0] tag);
    bit done = 0;
    in_valid = 1'b1; in_instr = w; in_pc = pc; in_tag = tag;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({model(w), pc, tag});
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk(1'b0, "accept_timeout", EW'(w), '0);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(exp_q.size() == 0, "drain", EW'(exp_q.size()), '0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs[10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67,
                             7'h03, 7'h23, 7'h63, 7'h7F};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 11);
    if (k < 10) w[6:0] = opcs[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0] held;
  bit            held_v = 0;
  always @(negedge clk) begin
    logic [EW-1:0] act, exp, m;
    if (rst) begin
      held_v = 0;
    end else begin
      act = act_vec();
      if (held_v)
        chk(out_valid && act == held, "hold_stable", act, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_output", act, '0);
        end else begin
          exp = exp_q.pop_front();
          m = exp[PC_W+TAG_W] ?
              {pack(3'h7, 1'b1, 2'b0, 1'b0, 32'h0, 5'h0, 5'h0, 5'h0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1), {(PC_W+TAG_W){1'b1}}}
              : {EW{1'b1}};
          chk(((act ^ exp) & m) == '0, "bundle", act, exp);
        end
      end
      held_v = out_valid && !out_ready;
      held = act;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] dir[12] = '{32'h002081B3, 32'h402081B3, 32'h007342B3,
                             32'h0020F1B3, 32'h0020E1B3, 32'h40315093,
                             32'hFFF00093, 32'h0020C063, 32'h00208063,
                             32'h0000007F, 32'h022081B3, 32'h00000013};
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_tag = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "rst_out_valid", EW'(out_valid), '0);
    chk(in_ready == 1'b0, "rst_in_ready", EW'(in_ready), '0);
    chk(act_vec() == '0, "rst_data", act_vec(), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk(in_ready == 1'b1, "post_rst_in_ready", EW'(in_ready), EW'(1));

    // directed decode, one-cycle latency on the first accept
    rdy_mode = 1;
    @(posedge clk); #1;
    send(dir[0], 32'h1000, 4'd0);
    chk(out_valid == 1'b1, "latency", EW'(out_valid), EW'(1));
    for (int i = 1; i < 12; i++)
      send(dir[i], 32'h1000 + 32'(4 * i), 4'(i));
    wait_drain();

    // backpressure: two fill main+skid, third waits until release
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(32'h002081B3, 32'h2000, 4'd1);
    send(32'h402081B3, 32'h2004, 4'd2);
    chk(in_ready == 1'b0, "bp_in_ready", EW'(in_ready), '0);
    fork
      send(32'h007342B3, 32'h2008, 4'd3);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk(in_ready == 1'b0, "bp_still_full", EW'(in_ready), '0);
        rdy_mode = 1;
      end
    join
    wait_drain();

    // reset with both entries full
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(32'h0020C063, 32'h3000, 4'd4);
    send(32'h00208063, 32'h3004, 4'd5);
    chk(out_valid && !in_ready, "full_before_rst",
        EW'({out_valid, in_ready}), EW'(2'b10));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk(out_valid == 1'b0, "flush_out_valid", EW'(out_valid), '0);
    chk(act_vec() == '0, "flush_data", act_vec(), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk(in_ready == 1'b1 && out_valid == 1'b0, "flush_in_ready",
        EW'({in_ready, out_valid}), EW'(2'b10));

    // random traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(rand_instr(), 32'($urandom), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    rdy_mode = 1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
